// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared states and constants for the pc_sequencer next-PC controller
package pc_seq_pkg;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;
  localparam int XLEN_DEF = 32;
  localparam int CAUSE_INSTR_MISALIGNED = 0;
  localparam logic [1:0] ALIGN_MASK = 2'b11;
endpackage

// File: rtl/pc_reg_en.sv
// pc_reg_en: enabled register with async active-low reset and a reset-value parameter
// Ports: clk, reset_n, en_i (load enable), d_i (next value), q_o (registered value)
module pc_reg_en #(
  parameter int W = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  always_comb q_d = en_i ? d_i : q_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q_q <= RST_VAL;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: RV32I next-PC controller with boot delay, halt, and misaligned-target trap
// Ports: clk, reset_n; stall/halt/resume/mret/jump/branch controls and targets in;
//        pc_o, pc_plus4_o, fetch_en_o, trap_o, epc_o, state_o out.
// Optional: PC_SEQ_INSTRET_EN adds instret_o[63:0], a retired-instruction counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100),
  parameter int BOOT_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            mret_i,
  input  logic            halt_i,
  input  logic            resume_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            fetch_en_o,
  output logic            trap_o,
  output logic [XLEN-1:0] epc_o,
`ifdef PC_SEQ_INSTRET_EN
  output logic [63:0]     instret_o,
`endif
  output logic [1:0]      state_o
);
  localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CW-1:0] BOOT_INIT = CW'(BOOT_CYCLES - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic trap_q, trap_d;
  logic [XLEN-1:0] pc_q, epc_q, pc_d, cand;
  logic adv, take_trap;
  // adv: an unstalled, non-halting RUN edge where the PC actually moves
  assign adv = (state_q == RUN) && !stall_i && !halt_i;
  assign cand = jump_i ? jump_target_i : branch_target_i;
  assign take_trap = adv && !mret_i && (jump_i || branch_taken_i) && |(cand[1:0] & ALIGN_MASK);
  always_comb pc_d = mret_i ? epc_q : take_trap ? TRAP_VEC : (jump_i || branch_taken_i) ? cand : pc_plus4_o;
  always_comb trap_d = take_trap;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      BOOT: begin
        state_d = (cnt_q == '0) ? RUN : BOOT;
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
      end
      RUN: state_d = (!stall_i && halt_i) ? HALT : RUN;
      HALT: state_d = (!stall_i && resume_i && !halt_i) ? RUN : HALT;
      default: begin
        state_d = BOOT;
        cnt_d = BOOT_INIT;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= BOOT;
      cnt_q <= BOOT_INIT;
      trap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      trap_q <= trap_d;
    end
  pc_reg_en #(.W(XLEN), .RST_VAL(RESET_VEC)) u_pc (
    .clk(clk), .reset_n(reset_n), .en_i(adv), .d_i(pc_d), .q_o(pc_q));
  // epc captures the PC of the faulting control-flow instruction
  pc_reg_en #(.W(XLEN), .RST_VAL('0)) u_epc (
    .clk(clk), .reset_n(reset_n), .en_i(take_trap), .d_i(pc_q), .q_o(epc_q));
`ifdef PC_SEQ_INSTRET_EN
  logic [63:0] instret_q, instret_d;
  always_comb instret_d = instret_q + {63'd0, adv && !take_trap};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) instret_q <= '0;
    else instret_q <= instret_d;
  assign instret_o = instret_q;
`endif
  assign pc_o = pc_q;
  assign pc_plus4_o = pc_q + XLEN'(4);
  assign fetch_en_o = (state_q == RUN);
  assign trap_o = trap_q;
  assign epc_o = epc_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a behavioural model
module tb_pc_sequencer;
  localparam int BOOT_N = 4;
  localparam logic [31:0] TRAP = 32'h100;
  logic clk = 1'b0;
  logic reset_n, stall_i, branch_taken_i, jump_i, mret_i, halt_i, resume_i;
  logic [31:0] branch_target_i, jump_target_i;
  logic [31:0] pc_o, pc_plus4_o, epc_o;
  logic fetch_en_o, trap_o;
  logic [1:0] state_o;
`ifdef PC_SEQ_INSTRET_EN
  logic [63:0] instret_o;
`endif
  int vec = 0;
  int miss = 0;
  int mst, boot_n;
  logic [31:0] mpc, mepc;
  logic mtrap;
  logic [63:0] mins;

  pc_sequencer dut (
    .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i), .jump_i(jump_i), .jump_target_i(jump_target_i),
    .mret_i(mret_i), .halt_i(halt_i), .resume_i(resume_i), .pc_o(pc_o),
    .pc_plus4_o(pc_plus4_o), .fetch_en_o(fetch_en_o), .trap_o(trap_o), .epc_o(epc_o),
`ifdef PC_SEQ_INSTRET_EN
    .instret_o(instret_o),
`endif
    .state_o(state_o));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vec++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic model_reset();
    mst = 0; boot_n = 0; mpc = 32'h0; mepc = 32'h0; mtrap = 1'b0; mins = 64'd0;
  endtask

  // Model: BOOT counts edges since reset release; RUN applies the priority rules directly.
  task automatic model_edge();
    logic [31:0] t;
    if (!reset_n) return;
    mtrap = 1'b0;
    if (mst == 0) begin
      boot_n++;
      if (boot_n == BOOT_N) mst = 1;
    end else if (mst == 2) begin
      if (!stall_i && resume_i && !halt_i) mst = 1;
    end else if (!stall_i) begin
      if (halt_i) mst = 2;
      else if (mret_i) begin mpc = mepc; mins++; end
      else if (jump_i || branch_taken_i) begin
        t = jump_i ? jump_target_i : branch_target_i;
        if (t % 4 != 0) begin mepc = mpc; mpc = TRAP; mtrap = 1'b1; end
        else begin mpc = t; mins++; end
      end else begin mpc = mpc + 32'd4; mins++; end
    end
  endtask

  task automatic check_all();
    logic [31:0] p4;
    p4 = mpc + 32'd4;
    chk("pc", pc_o, mpc);
    chk("pc_plus4", pc_plus4_o, p4);
    chk("fetch_en", fetch_en_o, mst == 1);
    chk("trap", trap_o, mtrap);
    chk("epc", epc_o, mepc);
    chk("state", state_o, mst[1:0]);
`ifdef PC_SEQ_INSTRET_EN
    chk("instret", instret_o, mins);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_in(input logic st, input logic br, input logic [31:0] bt, input logic jp,
                        input logic [31:0] jt, input logic mr, input logic hl, input logic rs);
    stall_i = st; branch_taken_i = br; branch_target_i = bt; jump_i = jp;
    jump_target_i = jt; mret_i = mr; halt_i = hl; resume_i = rs;
  endtask

  task automatic idle();
    set_in(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] bt, jt;
    reset_n = 1'b0;
    idle();
    model_reset();
    #3;
    check_all();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_fetch", fetch_en_o, 0);
    chk("rst_state", state_o, 0);
    #4 reset_n = 1'b1;
    repeat (3) begin cycle(); chk("boot_fetch_low", fetch_en_o, 0); end
    cycle();
    chk("boot_fetch_high", fetch_en_o, 1);
    chk("boot_pc0", pc_o, 32'h0);
    cycle(); chk("seq4", pc_o, 32'h4);
    cycle(); chk("seq8", pc_o, 32'h8);
    cycle(); chk("seq12", pc_o, 32'hC);
    set_in(0, 0, 0, 1, 32'h10, 0, 0, 0); cycle(); chk("jump10", pc_o, 32'h10);
    set_in(1, 1, 32'h40, 0, 0, 0, 0, 0); cycle(); chk("stall_hold", pc_o, 32'h10);
    set_in(0, 1, 32'h40, 0, 0, 0, 0, 0); cycle(); chk("branch40", pc_o, 32'h40);
    set_in(0, 0, 0, 1, 32'h20, 0, 0, 0); cycle();
    set_in(0, 0, 0, 1, 32'h42, 0, 0, 0); cycle();
    chk("trap_pc", pc_o, 32'h100);
    chk("trap_epc", epc_o, 32'h20);
    chk("trap_pulse", trap_o, 1);
    set_in(0, 0, 0, 0, 0, 1, 0, 0); cycle();
    chk("mret_pc", pc_o, 32'h20);
    chk("trap_drop", trap_o, 0);
    set_in(0, 1, 32'hC0, 1, 32'h80, 0, 0, 0); cycle(); chk("jump_prio", pc_o, 32'h80);
    set_in(0, 0, 0, 1, 32'h200, 0, 1, 0); cycle();
    chk("halt_state", state_o, 2);
    chk("halt_pc", pc_o, 32'h80);
    chk("halt_fetch", fetch_en_o, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 1); cycle();
    chk("resume_state", state_o, 1);
    chk("resume_pc", pc_o, 32'h80);
    set_in(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0); cycle();
    idle(); cycle();
    chk("wrap_pc", pc_o, 32'h0);
    chk("wrap_notrap", trap_o, 0);
    set_in(0, 0, 0, 1, 32'h42, 0, 0, 0); cycle();
    chk("trap2_pulse", trap_o, 1);
    reset_n = 1'b0;
    idle();
    #1;
    model_reset();
    check_all();
    chk("midrst_pc", pc_o, 32'h0);
    chk("midrst_epc", epc_o, 32'h0);
    chk("midrst_trap", trap_o, 0);
    #2 reset_n = 1'b1;
    repeat (BOOT_N + 3) cycle();
`ifdef PC_SEQ_INSTRET_EN
    chk("instret3", instret_o, 64'd3);
`endif
    chk("after3_pc", pc_o, 32'hC);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 reset_n = 1'b1;
      end
      bt = $urandom();
      jt = $urandom();
      if ($urandom_range(3) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(3) != 0) jt[1:0] = 2'b00;
      set_in($urandom_range(7) == 0, $urandom_range(3) == 0, bt, $urandom_range(3) == 0, jt,
             $urandom_range(15) == 0, $urandom_range(15) == 0, $urandom_range(3) == 0);
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the single-cycle RV32I core; owns the program counter and decides its value every cycle.
- Selects sequential, branch, jump, trap or return target, applies stall and halt, and enforces a post-reset boot delay before fetch.
- Detects misaligned control-flow targets and redirects to a trap vector, saving the faulting PC.
- Sits between the decode/ALU branch logic and instruction memory.

Parameters:
- XLEN, 32, PC/address width.
- RESET_VEC, 32'h0000_0000, PC value loaded at reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on misaligned-target trap.
- BOOT_CYCLES, 4, cycles after reset release before fetch_en_o asserts; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stall_i  in  1  freeze PC; all other control inputs ignored.
- branch_taken_i  in  1  conditional branch resolved taken.
- branch_target_i  in  XLEN  branch target.
- jump_i  in  1  JAL/JALR.
- jump_target_i  in  XLEN  jump target; JALR bit 0 already cleared upstream.
- mret_i  in  1  return from trap to epc_o.
- halt_i  in  1  enter HALT (EBREAK or debug).
- resume_i  in  1  leave HALT.
- pc_o  out  XLEN  current PC (registered).
- pc_plus4_o  out  XLEN  pc_o + 4, combinational, for the link register.
- fetch_en_o  out  1  instruction fetch and retire permitted.
- trap_o  out  1  one-cycle pulse, registered, on trap entry.
- epc_o  out  XLEN  PC of the instruction that trapped.
- state_o  out  2  FSM state, for debug.

Behaviour:
- Reset, asynchronous, while reset_n = 0:
  - pc_o = RESET_VEC, epc_o = 0, trap_o = 0, fetch_en_o = 0.
  - State = BOOT; boot counter = BOOT_CYCLES-1.
- States: BOOT=0, RUN=1, HALT=2. Encoding 3 is unused and recovers to BOOT on the next edge.
- BOOT:
  - Counter decrements each edge; PC is held and all inputs are ignored.
  - When the counter is 0, the next edge enters RUN.
  - fetch_en_o asserts exactly BOOT_CYCLES edges after reset_n rises.
- RUN: fetch_en_o = 1 combinationally, derived from state. Each edge applies the first matching rule:
  1. stall_i = 1: PC, epc and state hold; trap_o = 0.
  2. halt_i = 1: enter HALT; PC holds.
  3. mret_i = 1: PC <= epc_o.
  4. jump_i = 1: candidate = jump_target_i.
  5. branch_taken_i = 1: candidate = branch_target_i.
  6. Otherwise: PC <= pc_o + 4, with modulo-2^XLEN wrap (FFFF_FFFC -> 0000_0000).
- Misaligned candidate (rules 4 and 5 only), i.e. candidate[1:0] != 0:
  - PC <= TRAP_VEC, epc <= pc_o, trap_o = 1 for exactly that next cycle.
  - A trap taken while already at TRAP_VEC is legal; epc is overwritten.
- Aligned candidate: PC <= candidate.
- mret_i to a misaligned epc is not checked; epc is always 4-aligned by construction.
- HALT: fetch_en_o = 0; PC held. resume_i (with stall_i = 0) returns to RUN on the next edge with PC unchanged. halt_i and resume_i both high stays in HALT.
- Reset asserted mid-operation (any state, including a trap_o cycle) immediately forces the reset values.
- All outputs except pc_plus4_o and fetch_en_o are registered. Redirect latency is 1 cycle; there is no bubble.

Optional Feature:
- PC_SEQ_INSTRET_EN, when defined:
  - Adds output instret_o [63:0], reset 0.
  - Increments on every RUN edge with stall_i = 0, halt_i = 0 and no trap taken; wraps at 2^64.
- When undefined: port and counter are absent.

Decomposition:
- Package pc_seq_pkg holds:
  - state enum/localparams BOOT, RUN, HALT;
  - XLEN default;
  - CAUSE_INSTR_MISALIGNED = 0;
  - ALIGN_MASK = 2'b11.
- One natural sub-module, pc_reg_en: a parameterised-width register with async active-low reset, reset value parameter and enable. Instantiate it for the PC and for the epc.
- The FSM and next-PC mux stay in the top level.

Test Plan:
- Reset release, BOOT_CYCLES = 4 -> fetch_en_o low for 4 edges, then high; pc_o = 0, then 4, 8, 12 on the following edges.
- Branch in RUN at pc = 0x10, target 0x40 -> pc_o = 0x40 next cycle. The same branch with stall_i = 1 -> pc_o stays 0x10.
- Jump to 0x42 at pc = 0x20 -> pc_o = 0x100, epc_o = 0x20, trap_o high for one cycle. Then mret_i -> pc_o = 0x20.
- jump_i and branch_taken_i together, targets 0x80 and 0xC0 -> pc_o = 0x80. halt_i with jump_i -> HALT, pc unchanged. resume_i -> RUN, pc unchanged.
- pc = 0xFFFF_FFFC, sequential step -> pc_o = 0x0000_0000, no trap.
- reset_n pulsed low during the trap_o cycle -> pc_o = 0, epc_o = 0, trap_o = 0 immediately. With PC_SEQ_INSTRET_EN, instret_o = 0 and counts 3 after 3 unstalled RUN edges.
